// File: rtl/reg_alu_datapath.sv
// Register/ALU datapath: X, Y, Z working registers driven by per-register transfer codes.
// Optional REG_ALU_FLAGS_EN adds registered C/Z/N/V flags updated on every Y load.
module reg_alu_datapath #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic [1:0]       Tx,
    input  logic [1:0]       Ty,
    input  logic [1:0]       Tz,
    input  logic             Talu,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    output logic [WIDTH-1:0] z_out,
    output logic [WIDTH-1:0] alu_out,
`ifdef REG_ALU_FLAGS_EN
    output logic             z_valid,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v
`else
    output logic             z_valid
`endif
);

    typedef enum logic [1:0] {
        CODE_CLEAR  = 2'b00,
        CODE_LOAD   = 2'b01,
        CODE_HOLD   = 2'b10,
        CODE_SHIFTL = 2'b11
    } regCode_t;

    regCode_t xCode, yCode, zCode;
    logic [WIDTH-1:0] xReg, yReg, zReg;
    logic [WIDTH-1:0] xNext, yNext, zNext;
    logic [WIDTH-1:0] operandB, aluResult;
    logic             zValidReg;

    assign xCode = regCode_t'(Tx);
    assign yCode = regCode_t'(Ty);
    assign zCode = regCode_t'(Tz);

    // Subtraction reuses the adder as X + ~Y + 1, so carry out equals NOT borrow.
    assign operandB = Talu ? ~yReg : yReg;

`ifdef REG_ALU_FLAGS_EN
    logic aluCarry;
    logic aluOverflow;
    assign {aluCarry, aluResult} = {1'b0, xReg} + {1'b0, operandB} + (WIDTH+1)'(Talu);
    assign aluOverflow = (xReg[WIDTH-1] == operandB[WIDTH-1]) &&
                         (aluResult[WIDTH-1] != xReg[WIDTH-1]);
`else
    assign aluResult = xReg + operandB + WIDTH'(Talu);
`endif

    function automatic logic [WIDTH-1:0] applyCode(
        input regCode_t         code,
        input logic [WIDTH-1:0] current,
        input logic [WIDTH-1:0] loadValue
    );
        logic [WIDTH-1:0] result;
        result = current;
        case (code)
            CODE_CLEAR:  result = '0;
            CODE_LOAD:   result = loadValue;
            CODE_HOLD:   result = current;
            CODE_SHIFTL: result = {current[WIDTH-2:0], 1'b0};
            default:     result = current;
        endcase
        return result;
    endfunction

    // Every load source is a pre-edge value, so simultaneous codes never see each other's results.
    always_comb begin
        xNext = applyCode(xCode, xReg, data_in);
        yNext = applyCode(yCode, yReg, aluResult);
        zNext = applyCode(zCode, zReg, yReg);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            xReg      <= '0;
            yReg      <= '0;
            zReg      <= '0;
            zValidReg <= 1'b0;
        end else begin
            xReg      <= xNext;
            yReg      <= yNext;
            zReg      <= zNext;
            zValidReg <= (zCode == CODE_LOAD);
        end
    end

`ifdef REG_ALU_FLAGS_EN
    logic flagCReg, flagZReg, flagNReg, flagVReg;

    always_ff @(posedge clock) begin
        if (!reset) begin
            flagCReg <= 1'b0;
            flagZReg <= 1'b0;
            flagNReg <= 1'b0;
            flagVReg <= 1'b0;
        end else if (yCode == CODE_LOAD) begin
            flagCReg <= aluCarry;
            flagZReg <= (aluResult == '0);
            flagNReg <= aluResult[WIDTH-1];
            flagVReg <= aluOverflow;
        end
    end

    assign flag_c = flagCReg;
    assign flag_z = flagZReg;
    assign flag_n = flagNReg;
    assign flag_v = flagVReg;
`endif

    assign x_out   = xReg;
    assign y_out   = yReg;
    assign z_out   = zReg;
    assign alu_out = aluResult;
    assign z_valid = zValidReg;

endmodule

// File: tb/tb_reg_alu_datapath.sv
// Self-checking bench for reg_alu_datapath: arithmetic reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_reg_alu_datapath;

    localparam int W = 8;
    localparam logic [1:0] CLR = 2'b00;
    localparam logic [1:0] LD  = 2'b01;
    localparam logic [1:0] HLD = 2'b10;
    localparam logic [1:0] SHL = 2'b11;

    logic         clock   = 1'b0;
    logic         reset   = 1'b0;
    logic [W-1:0] data_in = '0;
    logic [1:0]   Tx      = HLD;
    logic [1:0]   Ty      = HLD;
    logic [1:0]   Tz      = HLD;
    logic         Talu    = 1'b0;
    logic [W-1:0] x_out, y_out, z_out, alu_out;
    logic         z_valid;
`ifdef REG_ALU_FLAGS_EN
    logic flag_c, flag_z, flag_n, flag_v;
`endif

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;

    reg_alu_datapath #(.WIDTH(W)) dut (
        .clock   (clock),
        .reset   (reset),
        .data_in (data_in),
        .Tx      (Tx),
        .Ty      (Ty),
        .Tz      (Tz),
        .Talu    (Talu),
        .x_out   (x_out),
        .y_out   (y_out),
        .z_out   (z_out),
        .alu_out (alu_out),
`ifdef REG_ALU_FLAGS_EN
        .z_valid (z_valid),
        .flag_c  (flag_c),
        .flag_z  (flag_z),
        .flag_n  (flag_n),
        .flag_v  (flag_v)
`else
        .z_valid (z_valid)
`endif
    );

    always #5 clock = ~clock;

    // Reference model: plain integer arithmetic on the architectural register values.
    logic [W-1:0] mX = '0, mY = '0, mZ = '0;
    logic         mZv = 1'b0;
    logic         mC = 1'b0, mZf = 1'b0, mN = 1'b0, mV = 1'b0;

    function automatic logic [W-1:0] aluModel(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic op);
        int r;
        r = op ? (int'(x) - int'(y)) : (int'(x) + int'(y));
        r = ((r % 256) + 256) % 256;
        return r[W-1:0];
    endfunction

    function automatic logic [W-1:0] codeModel(input logic [1:0] code, input logic [W-1:0] cur,
                                               input logic [W-1:0] loadVal);
        int r;
        case (code)
            CLR:     r = 0;
            LD:      r = int'(loadVal);
            HLD:     r = int'(cur);
            default: r = (int'(cur) * 2) % 256;
        endcase
        return r[W-1:0];
    endfunction

    always @(posedge clock) begin
        logic [W-1:0] nx, ny, nz, res;
        int sx, sy, sres;
        if (!reset) begin
            mX = '0; mY = '0; mZ = '0; mZv = 1'b0;
            mC = 1'b0; mZf = 1'b0; mN = 1'b0; mV = 1'b0;
        end else begin
            res = aluModel(mX, mY, Talu);
            nx  = codeModel(Tx, mX, data_in);
            ny  = codeModel(Ty, mY, res);
            nz  = codeModel(Tz, mZ, mY);
            if (Ty == LD) begin
                sx   = int'($signed(mX));
                sy   = int'($signed(mY));
                sres = Talu ? (sx - sy) : (sx + sy);
                mC   = Talu ? (int'(mX) >= int'(mY)) : ((int'(mX) + int'(mY)) > 255);
                mZf  = (res == 0);
                mN   = (int'(res) >= 128);
                mV   = (sres > 127) || (sres < -128);
            end
            mZv = (Tz == LD);
            mX = nx; mY = ny; mZ = nz;
        end
    end

    task automatic checkOutput(input string name, input logic [W-1:0] actual,
                               input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Single compare process: DUT against the model on every falling edge once enabled.
    always @(negedge clock) begin
        if (checkEn) begin
            checkOutput("x_out",   x_out,   mX);
            checkOutput("y_out",   y_out,   mY);
            checkOutput("z_out",   z_out,   mZ);
            checkOutput("z_valid", W'(z_valid), W'(mZv));
            checkOutput("alu_out", alu_out, aluModel(mX, mY, Talu));
`ifdef REG_ALU_FLAGS_EN
            checkOutput("flags", W'({flag_c, flag_z, flag_n, flag_v}), W'({mC, mZf, mN, mV}));
`endif
        end
    end

    task automatic setInputs(input logic rst, input logic [1:0] tx, input logic [1:0] ty,
                             input logic [1:0] tz, input logic talu, input logic [W-1:0] din);
        reset   = rst;
        Tx      = tx;
        Ty      = ty;
        Tz      = tz;
        Talu    = talu;
        data_in = din;
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic applyStimulus(input logic rst, input logic [1:0] tx, input logic [1:0] ty,
                                 input logic [1:0] tz, input logic talu, input logic [W-1:0] din);
        setInputs(rst, tx, ty, tz, talu, din);
        tick();
    endtask

    initial begin
        // Reset held with all-LOAD codes must leave everything cleared.
        applyStimulus(1'b0, LD, LD, LD, 1'b0, 8'hFF);
        applyStimulus(1'b0, LD, LD, LD, 1'b0, 8'hFF);
        checkOutput("rst_x", x_out, 8'h00);
        checkOutput("rst_y", y_out, 8'h00);
        checkOutput("rst_z", z_out, 8'h00);
        checkOutput("rst_zv", W'(z_valid), 8'h00);
        checkEn = 1'b1;

        applyStimulus(1'b1, LD, CLR, CLR, 1'b0, 8'd5);
        checkOutput("load_x5", x_out, 8'd5);
        applyStimulus(1'b1, LD, LD, HLD, 1'b0, 8'd3);
        checkOutput("load_x3", x_out, 8'd3);
        checkOutput("y_old_x", y_out, 8'd5);

        setInputs(1'b1, HLD, LD, HLD, 1'b1, 8'h00);
        #1;
        checkOutput("alu_sub_comb", alu_out, 8'hFE);
        tick();
        checkOutput("y_sub", y_out, 8'hFE);
        checkOutput("x_hold", x_out, 8'd3);
`ifdef REG_ALU_FLAGS_EN
        checkOutput("flag_c_sub", W'(flag_c), 8'h00);
        checkOutput("flag_n_sub", W'(flag_n), 8'h01);
        checkOutput("flag_z_sub", W'(flag_z), 8'h00);
`endif

        setInputs(1'b1, HLD, HLD, HLD, 1'b0, 8'h00);
        #1;
        checkOutput("alu_add_wrap", alu_out, 8'h01);
        tick();
        applyStimulus(1'b1, HLD, HLD, HLD, 1'b1, 8'h55);
        checkOutput("talu_dc_y", y_out, 8'hFE);

        applyStimulus(1'b1, LD, CLR, HLD, 1'b1, 8'hC1);
        applyStimulus(1'b1, HLD, LD, HLD, 1'b0, 8'h00);
        checkOutput("y_c1", y_out, 8'hC1);
        applyStimulus(1'b1, HLD, SHL, HLD, 1'b1, 8'h00);
        checkOutput("shl_1", y_out, 8'h82);
        applyStimulus(1'b1, HLD, SHL, HLD, 1'b0, 8'h00);
        checkOutput("shl_2", y_out, 8'h04);

        applyStimulus(1'b1, LD, CLR, HLD, 1'b0, 8'h82);
        applyStimulus(1'b1, HLD, LD, HLD, 1'b0, 8'h00);
        checkOutput("y_82", y_out, 8'h82);
        applyStimulus(1'b1, CLR, CLR, LD, 1'b0, 8'h00);
        checkOutput("z_load", z_out, 8'h82);
        checkOutput("z_clr_x", x_out, 8'h00);
        checkOutput("z_clr_y", y_out, 8'h00);
        checkOutput("zv_pulse", W'(z_valid), 8'h01);
        applyStimulus(1'b1, HLD, HLD, HLD, 1'b0, 8'h00);
        checkOutput("zv_drop", W'(z_valid), 8'h00);
        checkOutput("z_hold", z_out, 8'h82);

        // Reset wins over a simultaneous Z load; the following cycle behaves normally.
        applyStimulus(1'b0, HLD, HLD, LD, 1'b0, 8'h00);
        checkOutput("rst_zload_z", z_out, 8'h00);
        checkOutput("rst_zload_zv", W'(z_valid), 8'h00);
        applyStimulus(1'b1, LD, HLD, LD, 1'b0, 8'h09);
        checkOutput("post_rst_x", x_out, 8'h09);
        checkOutput("post_rst_zv", W'(z_valid), 8'h01);

        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 31) != 0), 2'($urandom), 2'($urandom),
                          2'($urandom), 1'($urandom), 8'($urandom));
        end

        @(negedge clock);
        checkEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
